// File: rtl/nn_input_frame_buffer.sv
// Ping-pong input frame buffer between the AXI-Stream pixel input and Layer_1.
// Optional tlast framing check is enabled by defining FRAME_LAST_CHECK_EN.
module nn_input_frame_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 784,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  s_axi_aclk,
   input  logic                  reset,
   input  logic                  soft_reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] x_data,
   output logic                  x_valid,
   input  logic                  nn_done,
   output logic [1:0]            frames_pending,
   output logic                  frame_err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_STREAM = 2'd1,
      RD_WAIT   = 2'd2
   } rd_state_t;

   logic                  clr;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [1:0]            full_q, full_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  fill_q, fill_d;
   logic                  fill_bank_q, fill_bank_d;
   logic                  credit_q, credit_d;
   rd_state_t             state_q, state_d;
   logic                  x_valid_q;
   logic [DATA_WIDTH-1:0] x_data_q;
   logic                  frame_err_q, frame_err_d;

   logic                  wr_fire;
   logic                  wr_last_beat;
   logic                  frame_drop;
   logic                  rd_en;
   logic                  rd_last;

   assign clr           = reset | soft_reset;
   assign wr_fire       = s_axis_tvalid & s_axis_tready;
   assign wr_last_beat  = (wr_count_q == LAST_ADDR);

   assign s_axis_tready  = ~full_q[wr_bank_q];
   assign frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign x_data         = x_data_q;
   assign x_valid        = x_valid_q;
   assign frame_err      = frame_err_q;

`ifdef FRAME_LAST_CHECK_EN
   // Early tlast abandons the partial frame; a missing tlast only flags it.
   assign frame_drop  = wr_fire & s_axis_tlast & ~wr_last_beat;
   assign frame_err_d = frame_drop | (wr_fire & wr_last_beat & ~s_axis_tlast);
`else
   logic tlast_unused;
   assign tlast_unused = s_axis_tlast;
   assign frame_drop   = 1'b0;
   assign frame_err_d  = 1'b0;
`endif

   always_comb begin
      wr_count_d  = wr_count_q;
      wr_bank_d   = wr_bank_q;
      fill_d      = 1'b0;
      fill_bank_d = wr_bank_q;
      if (wr_fire) begin
         if (frame_drop) begin
            wr_count_d = '0;
         end else if (wr_last_beat) begin
            wr_count_d = '0;
            wr_bank_d  = ~wr_bank_q;
            fill_d     = 1'b1;
         end else begin
            wr_count_d = wr_count_q + 1'b1;
         end
      end
   end

   // Network completion only counts once the last sample has left the buffer.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rd_bank_d = rd_bank_q;
      credit_d  = credit_q;
      rd_en     = 1'b0;
      rd_last   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (full_q[rd_bank_q] && credit_q) begin
               state_d   = RD_STREAM;
               rd_addr_d = '0;
               credit_d  = 1'b0;
            end
         end
         RD_STREAM: begin
            rd_en = 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               rd_last   = 1'b1;
               rd_bank_d = ~rd_bank_q;
               state_d   = RD_WAIT;
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         RD_WAIT: begin
            if (nn_done && !x_valid_q) begin
               credit_d = 1'b1;
               state_d  = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Full flag is set one edge after the closing beat, cleared after the last read address.
   always_comb begin
      full_d = full_q;
      if (rd_last) full_d[rd_bank_q] = 1'b0;
      if (fill_q) full_d[fill_bank_q] = 1'b1;
   end

   always_ff @(posedge s_axi_aclk) begin
      if (wr_fire) mem_q[{wr_bank_q, wr_count_q}] <= s_axis_tdata;
   end

   always_ff @(posedge s_axi_aclk) begin
      if (clr) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_count_q  <= '0;
         rd_addr_q   <= '0;
         fill_q      <= 1'b0;
         fill_bank_q <= 1'b0;
         credit_q    <= 1'b1;
         state_q     <= RD_IDLE;
         x_valid_q   <= 1'b0;
         x_data_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_count_q  <= wr_count_d;
         rd_addr_q   <= rd_addr_d;
         fill_q      <= fill_d;
         fill_bank_q <= fill_bank_d;
         credit_q    <= credit_d;
         state_q     <= state_d;
         x_valid_q   <= rd_en;
         if (rd_en) x_data_q <= mem_q[{rd_bank_q, rd_addr_q}];
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_nn_input_frame_buffer.sv
// Self-checking bench for nn_input_frame_buffer with an 8-sample frame.
module tb_nn_input_frame_buffer;

   localparam int DW = 16;
   localparam int FL = 8;
   localparam int AW = 4;

   logic          clk;
   logic          reset, soft_reset;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [DW-1:0] x_data;
   logic          x_valid;
   logic          nn_done;
   logic [1:0]    frames_pending;
   logic          frame_err;

   nn_input_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW)) dut (
      .s_axi_aclk     (clk),
      .reset          (reset),
      .soft_reset     (soft_reset),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .x_data         (x_data),
      .x_valid        (x_valid),
      .nn_done        (nn_done),
      .frames_pending (frames_pending),
      .frame_err      (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: every accepted sample in order, minus abandoned partial frames.
   logic [DW-1:0] exp_q[$];
   int            part_cnt   = 0;
   int            last_edge  = 0;
   int            cyc        = 0;
   int            run_len    = 0;
   int            bursts_done = 0;
   int            first_edge = 0;
   bit            saw_p2_t0  = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (frames_pending == 2'd2 && !s_axis_tready) saw_p2_t0 = 1;
      if (x_valid) begin
         if (run_len == 0) first_edge = cyc;
         run_len++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sample: got %0d with nothing outstanding", x_data);
         end else begin
            check("x_data", 32'(x_data), 32'(exp_q.pop_front()));
         end
      end else if (run_len > 0) begin
         check("burst_len", 32'(run_len), 32'(FL));
         bursts_done++;
         run_len = 0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input bit last);
      int g = 0;
      bit exp_err = 0;
      bit drop = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last;
      while (!s_axis_tready && g < 300) begin
         step();
         g++;
      end
      if (!s_axis_tready) begin
         n_checks++;
         n_fail++;
         $display("FAIL tready_timeout: got 0 expected 1 within 300 cycles");
         s_axis_tvalid = 1'b0;
         return;
      end
`ifdef FRAME_LAST_CHECK_EN
      exp_err = (last != (part_cnt == FL - 1));
      drop    = last && (part_cnt < FL - 1);
`endif
      exp_q.push_back(d);
      if (drop) begin
         for (int i = 0; i <= part_cnt; i++) void'(exp_q.pop_back());
         part_cnt = 0;
      end else begin
         part_cnt = (part_cnt + 1) % FL;
      end
      last_edge = cyc + 1;
      step();
      check("frame_err", 32'(frame_err), 32'(exp_err));
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] base, input logic [DW-1:0] inc,
                             input bit rnd, input int tlast_idx);
      for (int i = 0; i < FL; i++) begin
         if (rnd) repeat ($urandom_range(0, 3)) step();
         send_beat(rnd ? DW'($urandom) : DW'(base + DW'(i) * inc), i == tlast_idx);
      end
   endtask

   task automatic pulse_done();
      nn_done = 1'b1;
      step();
      nn_done = 1'b0;
   endtask

   task automatic wait_bursts(input int target);
      int g = 0;
      while (bursts_done < target && g < 300) begin
         step();
         g++;
      end
      check("burst_count", 32'(bursts_done), 32'(target));
   endtask

   typedef struct {
      logic [DW-1:0] base;
      logic [DW-1:0] inc;
      int            exp_lat;
      logic [1:0]    exp_pend;
   } vec_t;

   vec_t vt[4];
   int   nb;
   int   g;

   initial begin
      vt[0] = '{base: 16'd1,     inc: 16'd1,     exp_lat: 3, exp_pend: 2'd0};
      vt[1] = '{base: 16'd100,   inc: 16'd3,     exp_lat: 3, exp_pend: 2'd0};
      vt[2] = '{base: 16'hFFFC,  inc: 16'd1,     exp_lat: 3, exp_pend: 2'd0};
      vt[3] = '{base: 16'h8000,  inc: 16'h1111,  exp_lat: 3, exp_pend: 2'd0};

      reset         = 1'b1;
      soft_reset    = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      nn_done       = 1'b0;
      repeat (3) step();
      check("rst_tready", 32'(s_axis_tready), 32'd1);
      check("rst_x_valid", 32'(x_valid), 32'd0);
      check("rst_x_data", 32'(x_data), 32'd0);
      check("rst_pending", 32'(frames_pending), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      reset = 1'b0;
      step();

      // Single frames: latency from closing beat, data order, flags drained.
      for (int v = 0; v < 4; v++) begin
         nb = bursts_done;
         send_frame(vt[v].base, vt[v].inc, 0, FL - 1);
         wait_bursts(nb + 1);
         check("latency", 32'(first_edge - last_edge), 32'(vt[v].exp_lat));
         check("pending_after", 32'(frames_pending), 32'(vt[v].exp_pend));
         pulse_done();
      end

      // Three frames without nn_done: only the first is replayed.
      nb = bursts_done;
      saw_p2_t0 = 0;
      send_frame(16'd1, 16'd1, 0, FL - 1);
      send_frame(16'd11, 16'd1, 0, FL - 1);
      send_frame(16'd21, 16'd1, 0, FL - 1);
      repeat (20) step();
      check("pend2_tready0_seen", 32'(saw_p2_t0), 32'd1);
      check("hold_pending", 32'(frames_pending), 32'd2);
      check("hold_tready", 32'(s_axis_tready), 32'd0);
      check("hold_bursts", 32'(bursts_done), 32'(nb + 1));

      // nn_done releases frame 2; a done during its final sample is ignored.
      pulse_done();
      g = 0;
      while (!(x_valid && run_len == FL) && g < 100) begin
         step();
         g++;
      end
      check("final_sample_reached", 32'(x_valid && run_len == FL), 32'd1);
      nn_done = 1'b1;
      step();
      nn_done = 1'b0;
      wait_bursts(nb + 2);
      check("tready_after_release", 32'(s_axis_tready), 32'd1);
      repeat (20) step();
      check("early_done_ignored", 32'(bursts_done), 32'(nb + 2));
      check("pending_one_left", 32'(frames_pending), 32'd1);
      pulse_done();
      wait_bursts(nb + 3);
      pulse_done();

      // Reset and soft reset mid-frame discard the partial frame.
      for (int k = 0; k < 2; k++) begin
         nb = bursts_done;
         for (int i = 0; i < 5; i++) send_beat(DW'(101 + i), 1'b0);
         if (k == 0) reset = 1'b1;
         else soft_reset = 1'b1;
         step();
         reset      = 1'b0;
         soft_reset = 1'b0;
         exp_q.delete();
         part_cnt = 0;
         check("clr_pending", 32'(frames_pending), 32'd0);
         check("clr_x_valid", 32'(x_valid), 32'd0);
         check("clr_tready", 32'(s_axis_tready), 32'd1);
         send_frame(16'd31, 16'd1, 0, FL - 1);
         wait_bursts(nb + 1);
         pulse_done();
      end

      // tlast on beat 4.
      nb = bursts_done;
`ifdef FRAME_LAST_CHECK_EN
      for (int i = 0; i < 4; i++) send_beat(DW'(41 + i), i == 3);
      repeat (15) step();
      check("drop_no_burst", 32'(bursts_done), 32'(nb));
      check("drop_pending", 32'(frames_pending), 32'd0);
      send_frame(16'd51, 16'd1, 0, FL - 1);
      wait_bursts(nb + 1);
      pulse_done();
      send_frame(16'd61, 16'd1, 0, -1);
      wait_bursts(nb + 2);
      pulse_done();
`else
      send_frame(16'd41, 16'd1, 0, 3);
      wait_bursts(nb + 1);
      pulse_done();
`endif

      // Random tvalid and data over two frames.
      nb = bursts_done;
      send_frame(16'd0, 16'd0, 1, FL - 1);
      send_frame(16'd0, 16'd0, 1, FL - 1);
      wait_bursts(nb + 1);
      pulse_done();
      wait_bursts(nb + 2);
      pulse_done();
      repeat (5) step();

      check("model_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
